// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The ovf signal exists only when CLA_OVERFLOW_EN is defined.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CLA_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CLA_OVERFLOW_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic            clk,
  input logic            rst,
  cla_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  // Stage 1: per-bit and per-group propagate/generate
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
  logic [NG-1:0]    gp_q, gp_d, gg_q, gg_d;
  logic             c0_q, c0_d;

  // Stage 2: resolved result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef CLA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s1_load, s2_load;
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic [NG-1:0]    gp_in, gg_in;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;

  // Returns {P, G} of one group; the ripple is bounded to GROUP bits.
  function automatic logic [1:0] group_pg(input logic [GROUP-1:0] p,
                                          input logic [GROUP-1:0] g);
    logic pp, gg;
    pp = 1'b1;
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      pp = pp & p[i];
      gg = g[i] | (p[i] & gg);
    end
    return {pp, gg};
  endfunction

  // Flat lookahead: each group carry is a sum of products, no chain between groups.
  function automatic logic [NG:0] lookahead(input logic [NG-1:0] gp,
                                            input logic [NG-1:0] gg,
                                            input logic          c0);
    logic [NG:0] c;
    logic        term;
    c    = '0;
    c[0] = c0;
    for (int k = 1; k <= NG; k++) begin
      term = c0;
      for (int j = 0; j < k; j++) term = term & gp[j];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & gp[m];
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

  // Carry into each bit of a group, given the group's carry in.
  function automatic logic [GROUP-1:0] group_carries(input logic [GROUP-1:0] p,
                                                     input logic [GROUP-1:0] g,
                                                     input logic             c_in);
    logic [GROUP-1:0] cb;
    logic             c;
    c = c_in;
    for (int i = 0; i < GROUP; i++) begin
      cb[i] = c;
      c     = g[i] | (p[i] & c);
    end
    return cb;
  endfunction

  // S1 may advance whenever S2 is empty or draining this cycle.
  assign bus.in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);

  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    b_eff = bus.sub ? ~bus.b : bus.b;
    p_in  = bus.a ^ b_eff;
    g_in  = bus.a & b_eff;
    gp_in = '0;
    gg_in = '0;
    for (int k = 0; k < NG; k++) begin
      {gp_in[k], gg_in[k]} = group_pg(p_in[k*GROUP +: GROUP], g_in[k*GROUP +: GROUP]);
    end

    p_d        = s1_load ? p_in : p_q;
    g_d        = s1_load ? g_in : g_q;
    gp_d       = s1_load ? gp_in : gp_q;
    gg_d       = s1_load ? gg_in : gg_q;
    c0_d       = s1_load ? (bus.sub | bus.cin) : c0_q;
    s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
  end

  always_comb begin
    grp_c = lookahead(gp_q, gg_q, c0_q);
    bit_c = '0;
    for (int k = 0; k < NG; k++) begin
      bit_c[k*GROUP +: GROUP] = group_carries(p_q[k*GROUP +: GROUP],
                                              g_q[k*GROUP +: GROUP], grp_c[k]);
    end

    sum_d      = s2_load ? (p_q ^ bit_c) : sum_q;
    cout_d     = s2_load ? grp_c[NG] : cout_q;
`ifdef CLA_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    ovf_d      = s2_load ? (bit_c[WIDTH-1] ^ grp_c[NG]) : ovf_q;
`endif
    s2_valid_d = s2_load ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
`ifdef CLA_OVERFLOW_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  // NOTE: S1 datapath flops carry no reset; their contents matter only while s1_valid_q is set.
  always_ff @(posedge clk) begin
    p_q  <= p_d;
    g_q  <= g_d;
    gp_q <= gp_d;
    gg_q <= gg_d;
    c0_q <= c0_d;
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef CLA_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; legal values are multiples of 4, 4..64.
REQ-002 SHALL have parameter GROUP, default 4, carry-lookahead group size in bits; WIDTH SHALL be a multiple of GROUP.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present on a, b, cin, sub.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry in, used when sub=0.
REQ-010 SHALL have port sub  input  1  1 = compute a - b.
REQ-011 SHALL have port out_valid  output  1  sum, cout (and ovf) hold a valid result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result bits.
REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-015 SHALL compute {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), modulo 2^(WIDTH+1).
REQ-016 SHALL use two register stages: S1 registers per-bit propagate/generate and per-group P/G; S2 resolves inter-group lookahead carries and registers sum/cout.
REQ-017 SHALL not use a ripple chain longer than GROUP bits inside any stage.
REQ-018 SHALL accept an operand set on a rising edge where in_valid=1 and in_ready=1 (transfer).
REQ-019 SHALL present the result of a transfer with out_valid=1 exactly 2 cycles after the transfer when out_ready stays 1.
REQ-020 SHALL complete a result transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-021 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (S1 may advance whenever S2 is empty or draining).
REQ-022 SHALL sustain one transfer per cycle with out_ready held at 1.
REQ-023 SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL hold up to two operand sets in flight under backpressure: S1 full and S2 full drives in_ready=0.
REQ-025 SHALL handle simultaneous input and output transfer in one cycle with no bubble and no loss.
REQ-026 SHALL ignore a, b, cin and sub whenever no input transfer occurs.
REQ-027 SHALL deliver results in acceptance order; none dropped, none duplicated.

Reset
REQ-028 SHALL, on rst=1, immediately clear both stage valid flags, force out_valid=0, sum=0, cout=0 and ovf=0, independent of clk.
REQ-029 SHALL drive in_ready=1 while rst=1 and in the first cycle after release.
REQ-030 SHALL discard in-flight operand sets when rst asserts mid-operation; no stale result SHALL appear after release.

Configuration
REQ-031 SHALL, with macro CLA_OVERFLOW_EN defined, add port ovf  output  1, the two's-complement signed overflow of the operation, registered with sum and valid under the same out_valid.
REQ-032 SHALL, without CLA_OVERFLOW_EN, omit the ovf port and its logic; all other behaviour is identical.

Verification (WIDTH=16, GROUP=4)
REQ-033 SHALL cover: reset, then a=16'h00FF, b=16'h0001, cin=0, sub=0 accepted at cycle 0 -> out_valid at cycle 2 with sum=16'h0100, cout=0.
REQ-034 SHALL cover: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, carry propagating through all four groups.
REQ-035 SHALL cover: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0; with CLA_OVERFLOW_EN, a=16'h7FFF, b=16'h0001, sub=0 -> ovf=1.
REQ-036 SHALL cover: out_ready=0 while three back-to-back sets are offered -> in_ready falls after two acceptances, output stable; out_ready=1 -> all three results delivered in order.
REQ-037 SHALL cover: rst pulsed mid-clock with two sets in flight -> out_valid=0 at once, and no result emerges after release until a new transfer.
REQ-038 SHALL cover: 1000 random back-to-back transfers with random out_ready -> every result equals the reference sum, in order.
